// File: rtl/genpad_poll_scheduler.sv
// ============================================================================
// Module   : genpad_poll_scheduler
// Purpose  : Drives SELECT for two Genesis/SMS pad ports, samples 8 phases per
//            port, detects pad type and publishes decoded 12-bit button words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module genpad_poll_scheduler #(
    parameter int PHASE_CYC     = 50,
    parameter int GUARD_CYC     = 100000,
    parameter int AUTO_POLL_CYC = 833333
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iPOLL,
    input  logic [5:0]  iGENPAD0,
    input  logic [5:0]  iGENPAD1,
    output logic [1:0]  oSELECT,
    output logic [11:0] oBUTTONS0,
    output logic [11:0] oBUTTONS1,
    output logic [1:0]  oTYPE0,
    output logic [1:0]  oTYPE1,
    output logic [1:0]  oVALID,
    output logic        oBUSY,
    output logic        oOVERRUN
);

    localparam int c_PH_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam int c_GD_W = ($clog2(GUARD_CYC + 1) > 0) ? $clog2(GUARD_CYC + 1) : 1;
    localparam int c_AU_W = ($clog2(AUTO_POLL_CYC + 1) > 0) ? $clog2(AUTO_POLL_CYC + 1) : 1;
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(PHASE_CYC - 1);
    localparam logic [c_GD_W-1:0] c_GUARD   = c_GD_W'(GUARD_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PHASE  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                port_q, port_d;
    logic [2:0]          phase_q, phase_d;
    logic [c_PH_W-1:0]   cnt_q, cnt_d;
    logic [c_GD_W-1:0]   guard_q, guard_d;
    logic                pending_q, pending_d;
    logic                start_d;
    logic                sample_d;
    logic [5:0]          shadow_q [8];
    logic [11:0]         buttons0_q, buttons1_q;
    logic [1:0]          type0_q, type1_q;
    logic [1:0]          valid_q;
    logic                overrun_q;
    logic                w_tick;
    logic                w_req;
    logic                w_busy;
    logic [5:0]          w_lines;
    logic [11:0]         w_dec_btn;
    logic [1:0]          w_dec_type;

    // Free-running auto-poll divider; absent entirely when disabled.
    generate
        if (AUTO_POLL_CYC > 0) begin : g_auto
            localparam logic [c_AU_W-1:0] c_AU_LAST = c_AU_W'(AUTO_POLL_CYC - 1);
            logic [c_AU_W-1:0] auto_q;
            always_ff @(posedge iCLK) begin
                if (iRESET) begin
                    auto_q <= '0;
                end else if (auto_q == c_AU_LAST) begin
                    auto_q <= '0;
                end else begin
                    auto_q <= auto_q + 1'b1;
                end
            end
            assign w_tick = (auto_q == c_AU_LAST);
        end else begin : g_no_auto
            assign w_tick = 1'b0;
        end
    endgenerate

    assign w_busy  = (state_q != S_IDLE);
    assign w_req   = iPOLL | w_tick;
    assign w_lines = port_q ? iGENPAD1 : iGENPAD0;

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        guard_d   = (guard_q != '0) ? guard_q - 1'b1 : guard_q;
        start_d   = 1'b0;
        sample_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q && (guard_q == '0)) begin
                    start_d = 1'b1;
                    state_d = S_PHASE;
                    port_d  = 1'b0;
                    phase_d = 3'd0;
                    cnt_d   = '0;
                end
            end
            S_PHASE: begin
                if (cnt_q == c_PH_LAST) begin
                    sample_d = 1'b1;
                    cnt_d    = '0;
                    if (phase_q == 3'd7) begin
                        state_d = S_COMMIT;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMMIT: begin
                if (!port_q) begin
                    port_d  = 1'b1;
                    phase_d = 3'd0;
                    cnt_d   = '0;
                    state_d = S_PHASE;
                end else begin
                    guard_d = c_GUARD;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pending_d = (pending_q & ~start_d) | w_req;
    end

    // Samples are active low; the raw ph1/ph5 patterns identify the pad type.
    always_comb begin
        logic [5:0] p0;
        logic [5:0] p1;
        logic [5:0] p6;
        p0 = ~shadow_q[0];
        p1 = ~shadow_q[1];
        p6 = ~shadow_q[6];
        w_dec_btn  = {4'b0000, p1[5], p0[5], p0[4], p1[4], p0[3:0]};
        w_dec_type = 2'b01;
        if (shadow_q[1][1:0] != 2'b00) begin
            w_dec_type = 2'b00;
            w_dec_btn  = {5'b00000, p0[5], p0[4], 1'b0, p0[3:0]};
        end else if (shadow_q[5][3:0] == 4'b0000) begin
            w_dec_type      = 2'b10;
            w_dec_btn[11:8] = p6[3:0];
        end
    end

    always_ff @(posedge iCLK) begin
        if (sample_d) begin
            shadow_q[phase_q] <= w_lines;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q    <= S_IDLE;
            port_q     <= 1'b0;
            phase_q    <= 3'd0;
            cnt_q      <= '0;
            guard_q    <= c_GUARD;
            pending_q  <= 1'b0;
            buttons0_q <= '0;
            buttons1_q <= '0;
            type0_q    <= 2'b01;
            type1_q    <= 2'b01;
            valid_q    <= 2'b00;
            overrun_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            guard_q   <= guard_d;
            pending_q <= pending_d;
            overrun_q <= w_req & (pending_q | w_busy);
            valid_q   <= 2'b00;
            if (state_q == S_COMMIT) begin
                valid_q[port_q] <= 1'b1;
                if (!port_q) begin
                    buttons0_q <= w_dec_btn;
                    type0_q    <= w_dec_type;
                end else begin
                    buttons1_q <= w_dec_btn;
                    type1_q    <= w_dec_type;
                end
            end
        end
    end

    always_comb begin
        oSELECT = 2'b11;
        if (state_q == S_PHASE) begin
            oSELECT[port_q] = ~phase_q[0];
        end
    end

    assign oBUTTONS0 = buttons0_q;
    assign oBUTTONS1 = buttons1_q;
    assign oTYPE0    = type0_q;
    assign oTYPE1    = type1_q;
    assign oVALID    = valid_q;
    assign oBUSY     = w_busy;
    assign oOVERRUN  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_genpad_poll_scheduler.sv
// ============================================================================
// Module   : tb_genpad_poll_scheduler
// Purpose  : Directed bench with behavioural SMS / 3-button / 6-button pads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_genpad_poll_scheduler;

    localparam int c_P  = 4;
    localparam int c_G  = 60;
    localparam int c_TO = 40;

    logic        clk = 1'b0;
    logic        iRESET;
    logic        iPOLL;
    logic [5:0]  gp0, gp1;
    logic [1:0]  sel;
    logic [11:0] btn0, btn1;
    logic [1:0]  typ0, typ1;
    logic [1:0]  valid;
    logic        busy, ovr;

    int errors = 0;
    int checks = 0;
    int v0_cnt = 0, v1_cnt = 0, ovr_cnt = 0;
    logic both_low = 1'b0;

    // Pad kinds: 0 open, 1 SMS, 2 three-button, 3 six-button.
    logic [1:0]  kind [2];
    logic [11:0] held [2];
    int          lows [2];
    int          run  [2];
    logic        prev [2];

    genpad_poll_scheduler #(
        .PHASE_CYC     (c_P),
        .GUARD_CYC     (c_G),
        .AUTO_POLL_CYC (0)
    ) dut (
        .iCLK      (clk),
        .iRESET    (iRESET),
        .iPOLL     (iPOLL),
        .iGENPAD0  (gp0),
        .iGENPAD1  (gp1),
        .oSELECT   (sel),
        .oBUTTONS0 (btn0),
        .oBUTTONS1 (btn1),
        .oTYPE0    (typ0),
        .oTYPE1    (typ1),
        .oVALID    (valid),
        .oBUSY     (busy),
        .oOVERRUN  (ovr)
    );

    always #5 clk = ~clk;

    // h is in output-word order {Z,Y,X,M,S,C,B,A,U,D,L,R}, active high.
    function automatic logic [5:0] pad_lines(input logic [1:0] k, input logic [11:0] h,
                                             input logic s, input int n);
        logic [5:0] r;
        r = 6'h3F;
        if (k == 2'd1) begin
            r = ~{h[6], h[5], h[3], h[2], h[1], h[0]};
        end else if (k >= 2'd2) begin
            if (s) begin
                if (k == 2'd3 && n == 3) r = ~{h[6], h[5], h[11], h[10], h[9], h[8]};
                else                     r = ~{h[6], h[5], h[3], h[2], h[1], h[0]};
            end else begin
                if (k == 2'd3 && n == 3)      r = {~h[7], ~h[4], 4'b0000};
                else if (k == 2'd3 && n == 4) r = {~h[7], ~h[4], 4'b1111};
                else                          r = {~h[7], ~h[4], ~h[3], ~h[2], 2'b00};
            end
        end
        return r;
    endfunction

    assign gp0 = pad_lines(kind[0], held[0], sel[0], lows[0]);
    assign gp1 = pad_lines(kind[1], held[1], sel[1], lows[1]);

    // Six-button phase counter: counts SELECT falls, clears after a long high.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (prev[i] && !sel[i]) lows[i] <= lows[i] + 1;
            if (sel[i]) begin
                if (run[i] >= c_TO) lows[i] <= 0;
                else                run[i]  <= run[i] + 1;
            end else begin
                run[i] <= 0;
            end
            prev[i] <= sel[i];
        end
    end

    always @(negedge clk) begin
        if (!iRESET) begin
            if (valid[0]) v0_cnt  <= v0_cnt + 1;
            if (valid[1]) v1_cnt  <= v1_cnt + 1;
            if (ovr)      ovr_cnt <= ovr_cnt + 1;
            if (sel == 2'b00) both_low <= 1'b1;
        end
    end

    typedef struct packed {
        logic [1:0]  k0;
        logic [11:0] h0;
        logic [1:0]  k1;
        logic [11:0] h1;
        logic [1:0]  et0;
        logic [11:0] eb0;
        logic [1:0]  et1;
        logic [11:0] eb1;
    } vec_t;

    vec_t vecs [6];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_poll();
        iPOLL = 1'b1;
        tick(1);
        iPOLL = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input int limit);
        int n;
        n = 0;
        while (busy !== level && n < limit) begin
            tick(1);
            n++;
        end
        if (busy !== level) check("busy_timeout", {31'd0, busy}, {31'd0, level});
    endtask

    task automatic wait_sel0(input logic level, input int limit);
        int n;
        n = 0;
        while (sel[0] !== level && n < limit) begin
            tick(1);
            n++;
        end
        if (sel[0] !== level) check("sel0_timeout", {31'd0, sel[0]}, {31'd0, level});
    endtask

    task automatic run_scan();
        pulse_poll();
        wait_busy(1'b1, 10);
        wait_busy(1'b0, 200);
        tick(c_G + 5);
    endtask

    initial begin
        int b0, b1, o0, gap;
        // {k0, h0, k1, h1, et0, eb0, et1, eb1}
        vecs[0] = {2'd2, 12'h090, 2'd0, 12'h000, 2'b01, 12'h090, 2'b00, 12'h000};
        vecs[1] = {2'd0, 12'h000, 2'd3, 12'hA00, 2'b00, 12'h000, 2'b10, 12'hA00};
        vecs[2] = {2'd1, 12'h028, 2'd2, 12'h043, 2'b00, 12'h028, 2'b01, 12'h043};
        vecs[3] = {2'd3, 12'hFFF, 2'd1, 12'h046, 2'b10, 12'hFFF, 2'b00, 12'h046};
        vecs[4] = {2'd3, 12'h581, 2'd3, 12'h000, 2'b10, 12'h581, 2'b10, 12'h000};
        vecs[5] = {2'd1, 12'h041, 2'd2, 12'h024, 2'b00, 12'h041, 2'b01, 12'h024};

        for (int i = 0; i < 2; i++) begin
            kind[i] = 2'd0;
            held[i] = 12'h000;
            lows[i] = 0;
            run[i]  = 0;
            prev[i] = 1'b1;
        end
        iRESET = 1'b1;
        iPOLL  = 1'b0;
        tick(3);
        check("rst_select",   {30'd0, sel},   32'h3);
        check("rst_buttons0", {20'd0, btn0},  32'h0);
        check("rst_buttons1", {20'd0, btn1},  32'h0);
        check("rst_type0",    {30'd0, typ0},  32'h1);
        check("rst_type1",    {30'd0, typ1},  32'h1);
        check("rst_valid",    {30'd0, valid}, 32'h0);
        check("rst_busy",     {31'd0, busy},  32'h0);
        check("rst_overrun",  {31'd0, ovr},   32'h0);
        iRESET = 1'b0;
        tick(c_G + 5);

        for (int v = 0; v < 6; v++) begin
            kind[0] = vecs[v].k0;
            held[0] = vecs[v].h0;
            kind[1] = vecs[v].k1;
            held[1] = vecs[v].h1;
            b0 = v0_cnt;
            b1 = v1_cnt;
            run_scan();
            check($sformatf("v%0d_type0", v),   {30'd0, typ0}, {30'd0, vecs[v].et0});
            check($sformatf("v%0d_btn0", v),    {20'd0, btn0}, {20'd0, vecs[v].eb0});
            check($sformatf("v%0d_type1", v),   {30'd0, typ1}, {30'd0, vecs[v].et1});
            check($sformatf("v%0d_btn1", v),    {20'd0, btn1}, {20'd0, vecs[v].eb1});
            check($sformatf("v%0d_valid0", v),  v0_cnt - b0, 32'd1);
            check($sformatf("v%0d_valid1", v),  v1_cnt - b1, 32'd1);
        end

        // Three requests while the first one is being served.
        o0 = ovr_cnt;
        b1 = v1_cnt;
        pulse_poll();
        tick(10);
        pulse_poll();
        tick(10);
        pulse_poll();
        tick(2 * (16 * c_P + 2) + 2 * c_G + 100);
        check("merge_overruns", ovr_cnt - o0, 32'd2);
        check("merge_scans",    v1_cnt - b1,  32'd2);

        // Guard time between the end of a scan and the next SELECT fall.
        pulse_poll();
        wait_busy(1'b1, 10);
        wait_busy(1'b0, 200);
        iPOLL = 1'b1;
        gap = 0;
        while (sel[0] !== 1'b0 && gap < 500) begin
            tick(1);
            gap++;
        end
        iPOLL = 1'b0;
        check("guard_min", {31'd0, (gap >= c_G)}, 32'd1);
        check("guard_max", {31'd0, (gap <= c_G + 2 * c_P + 4)}, 32'd1);
        tick(2 * (16 * c_P + 2) + 2 * c_G + 100);

        // Reset in the middle of port 0 phase 4.
        pulse_poll();
        wait_busy(1'b1, 10);
        wait_sel0(1'b0, 100);
        wait_sel0(1'b1, 100);
        wait_sel0(1'b0, 100);
        wait_sel0(1'b1, 100);
        tick(1);
        b0 = v0_cnt;
        b1 = v1_cnt;
        iRESET = 1'b1;
        tick(1);
        check("abort_select",   {30'd0, sel},   32'h3);
        check("abort_buttons0", {20'd0, btn0},  32'h0);
        check("abort_buttons1", {20'd0, btn1},  32'h0);
        check("abort_type0",    {30'd0, typ0},  32'h1);
        check("abort_type1",    {30'd0, typ1},  32'h1);
        check("abort_busy",     {31'd0, busy},  32'h0);
        check("abort_valid",    {30'd0, valid}, 32'h0);
        iRESET = 1'b0;
        tick(200);
        check("abort_no_valid0", v0_cnt - b0, 32'd0);
        check("abort_no_valid1", v1_cnt - b1, 32'd0);
        check("never_both_low",  {31'd0, both_low}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
